// File: rtl/bcd_pkg.sv
// Shared types for the sequential binary-to-BCD converter: FSM states and
// the 4-bit BCD digit type used by the per-digit add-3 stage.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t ADJ_THRESHOLD = 4'd5;
   localparam bcd_digit_t ADJ_OFFSET    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or
// more so the following left shift carries correctly into the next digit.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  bcd_digit_t d,
   output bcd_digit_t q
);

   assign q = (d >= ADJ_THRESHOLD) ? bcd_digit_t'(d + ADJ_OFFSET) : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per clock.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int IN_W   = 27,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       bin,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic [DIGITS-1:0]     blank
);

   localparam int CNT_W = $clog2(IN_W + 1);

   state_t              state;
   state_t              state_next;
   logic [IN_W-1:0]     shreg;
   logic [4*DIGITS-1:0] acc;
   logic [4*DIGITS-1:0] adj;
   logic [4*DIGITS-1:0] acc_next;
   logic                ovf_acc;
   logic                ovf_next;
   logic [CNT_W-1:0]    count;
   logic                accept;
   logic                last_iter;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .d (acc[4*i +: 4]),
         .q (adj[4*i +: 4])
      );
   end

   // The bit leaving the top digit is the overflow indicator; the bin MSB
   // enters the bottom digit.
   assign acc_next  = {adj[4*DIGITS-2:0], shreg[IN_W-1]};
   assign ovf_next  = ovf_acc | adj[4*DIGITS-1];
   assign in_ready  = (state != SHIFT);
   assign accept    = in_valid && in_ready;
   assign last_iter = (state == SHIFT) && (count == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SHIFT;
         SHIFT:   if (count == CNT_W'(1)) state_next = DONE;
         DONE:    if (accept) state_next = SHIFT;
         default: state_next = IDLE;
      endcase
   end

   // Result registers only change on the final iteration, so they hold
   // steady through DONE and through the next conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg     <= '0;
         acc       <= '0;
         ovf_acc   <= 1'b0;
         count     <= '0;
         out_valid <= 1'b0;
         bcd       <= '0;
         ovf       <= 1'b0;
      end else if (accept) begin
         shreg     <= bin;
         acc       <= '0;
         ovf_acc   <= 1'b0;
         count     <= CNT_W'(IN_W);
         out_valid <= 1'b0;
      end else if (state == SHIFT) begin
         shreg   <= shreg << 1;
         acc     <= acc_next;
         ovf_acc <= ovf_next;
         count   <= count - CNT_W'(1);
         if (last_iter) begin
            out_valid <= 1'b1;
            bcd       <= ovf_next ? '0 : acc_next;
            ovf       <= ovf_next;
         end
      end
   end

`ifdef BCD_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_calc;
   logic              seen_nonzero;

   // Scan from the top digit down; digit 0 always stays lit.
   always_comb begin
      blank_calc   = '0;
      seen_nonzero = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (acc_next[4*i +: 4] != 4'd0) seen_nonzero = 1'b1;
         blank_calc[i] = ovf_next | ~seen_nonzero;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank <= '0;
      end else if (last_iter) begin
         blank <= blank_calc;
      end
   end
`else
   assign blank = '0;
`endif

endmodule
